// File: rtl/pong_pkg.sv
// pong_pkg: shared screen geometry, ball speed and game-flow state enum for the pong controller.
package pong_pkg;
  localparam int SCR_W        = 640;
  localparam int SCR_H        = 480;
  localparam int BALL         = 20;
  localparam int PAD_W        = 10;
  localparam int PAD_H        = 80;
  localparam int SPEED        = 5;
  localparam int SERVE_FRAMES = 60;
  localparam int WIN_SCORE    = 9;
  localparam logic [11:0] POS_V  = 12'(SPEED);
  localparam logic [11:0] NEG_V  = 12'(-SPEED);
  localparam logic [11:0] LOAD_X = 12'((SCR_W - BALL) / 2);
  localparam logic [11:0] LOAD_Y = 12'((SCR_H - BALL) / 2);
  typedef enum logic [2:0] {IDLE, SERVE, PLAY, SCORED, OVER} state_t;
  function automatic logic [3:0] score_inc(input logic [3:0] s);
    return (s == 4'd9) ? 4'd0 : s + 4'd1;
  endfunction
endpackage

// File: rtl/pong_ball_if.sv
// pong_ball_if: frame/paddle/ball inputs and load/step/velocity/score outputs of the ball controller.
interface pong_ball_if;
  logic        frame_tick;
  logic        start;
  logic [11:0] pad_l_y;
  logic [11:0] pad_r_y;
  logic [11:0] ball_x;
  logic [11:0] ball_y;
  logic        ball_load;
  logic [11:0] load_x;
  logic [11:0] load_y;
  logic        ball_step;
  logic [11:0] vel_x;
  logic [11:0] vel_y;
  logic [3:0]  score_l;
  logic [3:0]  score_r;
  logic        game_over;
  modport master (
    input  frame_tick, start, pad_l_y, pad_r_y, ball_x, ball_y,
    output ball_load, load_x, load_y, ball_step, vel_x, vel_y, score_l, score_r, game_over
  );
  modport slave (
    output frame_tick, start, pad_l_y, pad_r_y, ball_x, ball_y,
    input  ball_load, load_x, load_y, ball_step, vel_x, vel_y, score_l, score_r, game_over
  );
endinterface

// File: rtl/pong_hit_detect.sv
// pong_hit_detect: combinational wall, paddle-hit and miss flags for the current ball position.
module pong_hit_detect
  import pong_pkg::*;
(
  input  logic [11:0] ball_x_i,
  input  logic [11:0] ball_y_i,
  input  logic [11:0] pad_l_y_i,
  input  logic [11:0] pad_r_y_i,
  input  logic [11:0] vel_x_i,
  output logic        top_o,
  output logic        bot_o,
  output logic        hit_l_o,
  output logic        hit_r_o,
  output logic        miss_l_o,
  output logic        miss_r_o
);
  logic zone_l, zone_r, ovl_l, ovl_r;
  assign top_o    = ball_y_i <= 12'(SPEED);
  assign bot_o    = ball_y_i >= 12'(SCR_H - BALL - SPEED);
  // paddle zones only count when the ball is travelling toward that paddle
  assign zone_l   = vel_x_i[11] && ball_x_i <= 12'(PAD_W + SPEED);
  assign zone_r   = !vel_x_i[11] && vel_x_i != 12'd0 && ball_x_i >= 12'(SCR_W - PAD_W - BALL - SPEED);
  assign ovl_l    = (ball_y_i + 12'(BALL)) > pad_l_y_i && ball_y_i < (pad_l_y_i + 12'(PAD_H));
  assign ovl_r    = (ball_y_i + 12'(BALL)) > pad_r_y_i && ball_y_i < (pad_r_y_i + 12'(PAD_H));
  assign hit_l_o  = zone_l && ovl_l;
  assign hit_r_o  = zone_r && ovl_r;
  assign miss_l_o = zone_l && !ovl_l && ball_x_i <= 12'(SPEED);
  assign miss_r_o = zone_r && !ovl_r && ball_x_i >= 12'(SCR_W - BALL - SPEED);
endmodule

// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl: serve/play/score flow, per-frame velocity updates and scores for the ball datapath.
// Optional PONG_SCORE_LIMIT_EN: reaching WIN_SCORE enters OVER; otherwise scores wrap 9->0.
module pong_ball_ctrl
  import pong_pkg::*;
(
  input logic         clk,
  input logic         rst,
  pong_ball_if.master bus
);
  state_t      state_q;
  logic        start_q, load_q, step_q, serve_r_q, left_won_q;
  logic [5:0]  cnt_q;
  logic [11:0] vel_x_q, vel_y_q;
  logic [3:0]  score_l_q, score_r_q, score_d;
  logic        start_edge, top, bot, hit_l, hit_r, miss_l, miss_r;
  pong_hit_detect u_hit (
    .ball_x_i (bus.ball_x),
    .ball_y_i (bus.ball_y),
    .pad_l_y_i(bus.pad_l_y),
    .pad_r_y_i(bus.pad_r_y),
    .vel_x_i  (vel_x_q),
    .top_o    (top),
    .bot_o    (bot),
    .hit_l_o  (hit_l),
    .hit_r_o  (hit_r),
    .miss_l_o (miss_l),
    .miss_r_o (miss_r)
  );
  assign start_edge = bus.start && !start_q;
  assign score_d    = score_inc(left_won_q ? score_l_q : score_r_q);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      load_q     <= 1'b0;
      step_q     <= 1'b0;
      serve_r_q  <= 1'b1;
      left_won_q <= 1'b0;
      cnt_q      <= '0;
      vel_x_q    <= POS_V;
      vel_y_q    <= POS_V;
      score_l_q  <= '0;
      score_r_q  <= '0;
    end else begin
      start_q <= bus.start;
      load_q  <= 1'b0;
      step_q  <= 1'b0;
      case (state_q)
        IDLE, OVER: if (start_edge) begin
          score_l_q <= '0;
          score_r_q <= '0;
          cnt_q     <= '0;
          load_q    <= 1'b1;
          state_q   <= SERVE;
        end
        SERVE: if (bus.frame_tick) begin
          if (cnt_q == 6'(SERVE_FRAMES - 1)) begin
            vel_x_q <= serve_r_q ? POS_V : NEG_V;
            vel_y_q <= POS_V;
            cnt_q   <= '0;
            state_q <= PLAY;
          end else cnt_q <= cnt_q + 6'd1;
        end
        PLAY: if (bus.frame_tick) begin
          if (miss_l || miss_r) begin
            left_won_q <= miss_r;
            state_q    <= SCORED;
          end else begin
            step_q  <= 1'b1;
            vel_y_q <= top ? POS_V : bot ? NEG_V : vel_y_q;
            vel_x_q <= hit_l ? POS_V : hit_r ? NEG_V : vel_x_q;
          end
        end
        SCORED: begin
          if (left_won_q) score_l_q <= score_d;
          else score_r_q <= score_d;
          // the next serve heads toward the player who conceded
          serve_r_q <= left_won_q;
`ifdef PONG_SCORE_LIMIT_EN
          if (score_d == 4'(WIN_SCORE)) state_q <= OVER;
          else begin
            load_q  <= 1'b1;
            state_q <= SERVE;
          end
`else
          load_q  <= 1'b1;
          state_q <= SERVE;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.ball_load = load_q;
  assign bus.ball_step = step_q;
  assign bus.load_x    = LOAD_X;
  assign bus.load_y    = LOAD_Y;
  assign bus.vel_x     = vel_x_q;
  assign bus.vel_y     = vel_y_q;
  assign bus.score_l   = score_l_q;
  assign bus.score_r   = score_r_q;
`ifdef PONG_SCORE_LIMIT_EN
  assign bus.game_over = state_q == OVER;
`else
  assign bus.game_over = 1'b0;
`endif
endmodule

// File: tb/tb_pong_ball_ctrl.sv
// tb_pong_ball_ctrl: directed vector table plus serve/score/reset sequences for pong_ball_ctrl.
module tb_pong_ball_ctrl;
  localparam logic [11:0] P = 12'd5;
  localparam logic [11:0] N = 12'hFFB;
  typedef struct {
    logic [11:0] bx, by, pl, pr, vx, vy;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_fail = 0;
  int exp_sl = 0;
  pong_ball_if bus ();
  pong_ball_ctrl dut (.clk(clk), .rst(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic tick(input logic [11:0] bx, by, pl, pr);
    bus.ball_x = bx;
    bus.ball_y = by;
    bus.pad_l_y = pl;
    bus.pad_r_y = pr;
    bus.frame_tick = 1'b1;
    cyc();
    bus.frame_tick = 1'b0;
  endtask
  task automatic serve(input logic [11:0] evx);
    for (int i = 0; i < 60; i++) begin
      tick(12'd300, 12'd200, 12'd0, 12'd0);
      chk("serve_nostep", 32'(bus.ball_step), 32'd0);
      cyc();
    end
    tick(12'd300, 12'd200, 12'd0, 12'd0);
    chk("serve_first_step", 32'(bus.ball_step), 32'd1);
    chk("serve_vx", 32'(bus.vel_x), 32'(evx));
    chk("serve_vy", 32'(bus.vel_y), 32'(P));
    cyc();
  endtask
  task automatic start_pulse();
    bus.start = 1'b1;
    cyc();
    chk("start_load", 32'(bus.ball_load), 32'd1);
    bus.start = 1'b0;
    cyc();
    chk("start_load_gone", 32'(bus.ball_load), 32'd0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end
  initial begin
    vec_t v[16];
    v[0]  = '{12'd300, 12'd200, 12'd0,   12'd0,   P, P};
    v[1]  = '{12'd300, 12'd455, 12'd0,   12'd0,   P, N};
    v[2]  = '{12'd300, 12'd454, 12'd0,   12'd0,   P, N};
    v[3]  = '{12'd300, 12'd5,   12'd0,   12'd0,   P, P};
    v[4]  = '{12'd300, 12'd455, 12'd0,   12'd0,   P, N};
    v[5]  = '{12'd300, 12'd6,   12'd0,   12'd0,   P, N};
    v[6]  = '{12'd300, 12'd4,   12'd0,   12'd0,   P, P};
    v[7]  = '{12'd605, 12'd100, 12'd0,   12'd90,  N, P};
    v[8]  = '{12'd620, 12'd100, 12'd0,   12'd300, N, P};
    v[9]  = '{12'd15,  12'd100, 12'd90,  12'd300, P, P};
    v[10] = '{12'd604, 12'd100, 12'd0,   12'd300, P, P};
    v[11] = '{12'd610, 12'd100, 12'd0,   12'd300, P, P};
    v[12] = '{12'd605, 12'd100, 12'd0,   12'd120, P, P};
    v[13] = '{12'd605, 12'd100, 12'd0,   12'd119, N, P};
    v[14] = '{12'd16,  12'd455, 12'd300, 12'd300, N, N};
    v[15] = '{12'd14,  12'd4,   12'd0,   12'd300, P, P};
    bus.frame_tick = 1'b0;
    bus.start = 1'b0;
    bus.ball_x = '0;
    bus.ball_y = '0;
    bus.pad_l_y = '0;
    bus.pad_r_y = '0;
    repeat (3) cyc();
    chk("rst_load", 32'(bus.ball_load), 32'd0);
    chk("rst_step", 32'(bus.ball_step), 32'd0);
    chk("rst_vx", 32'(bus.vel_x), 32'(P));
    chk("rst_vy", 32'(bus.vel_y), 32'(P));
    chk("rst_sl", 32'(bus.score_l), 32'd0);
    chk("rst_sr", 32'(bus.score_r), 32'd0);
    chk("rst_over", 32'(bus.game_over), 32'd0);
    chk("load_x", 32'(bus.load_x), 32'd310);
    chk("load_y", 32'(bus.load_y), 32'd230);
    rst_n = 1'b1;
    cyc();
    tick(12'd300, 12'd200, 12'd0, 12'd0);
    chk("idle_tick_step", 32'(bus.ball_step), 32'd0);
    chk("idle_tick_load", 32'(bus.ball_load), 32'd0);
    cyc();
    start_pulse();
    serve(P);
    for (int i = 0; i < 16; i++) begin
      tick(v[i].bx, v[i].by, v[i].pl, v[i].pr);
      chk($sformatf("vec%0d_step", i), 32'(bus.ball_step), 32'd1);
      chk($sformatf("vec%0d_vx", i), 32'(bus.vel_x), 32'(v[i].vx));
      chk($sformatf("vec%0d_vy", i), 32'(bus.vel_y), 32'(v[i].vy));
      chk($sformatf("vec%0d_load", i), 32'(bus.ball_load), 32'd0);
      cyc();
      chk($sformatf("vec%0d_step_1cyc", i), 32'(bus.ball_step), 32'd0);
    end
    bus.start = 1'b1;
    cyc();
    chk("play_start_ignored", 32'(bus.ball_load), 32'd0);
    bus.start = 1'b0;
    tick(12'd605, 12'd100, 12'd0, 12'd90);
    chk("pre_miss_vx", 32'(bus.vel_x), 32'(N));
    cyc();
    tick(12'd6, 12'd100, 12'd300, 12'd0);
    chk("near_miss_step", 32'(bus.ball_step), 32'd1);
    chk("near_miss_sr", 32'(bus.score_r), 32'd0);
    cyc();
    tick(12'd4, 12'd100, 12'd300, 12'd0);
    chk("miss_l_step", 32'(bus.ball_step), 32'd0);
    chk("miss_l_load_early", 32'(bus.ball_load), 32'd0);
    cyc();
    chk("miss_l_load", 32'(bus.ball_load), 32'd1);
    chk("miss_l_step2", 32'(bus.ball_step), 32'd0);
    chk("miss_l_sr", 32'(bus.score_r), 32'd1);
    chk("miss_l_sl", 32'(bus.score_l), 32'd0);
    serve(N);
`ifdef PONG_SCORE_LIMIT_EN
    for (int k = 0; k < 9; k++) begin
`else
    for (int k = 0; k < 10; k++) begin
`endif
      tick(12'd15, 12'd100, 12'd90, 12'd300);
      chk("pt_vx_right", 32'(bus.vel_x), 32'(P));
      cyc();
      tick(12'd615, 12'd100, 12'd0, 12'd300);
      chk("pt_step", 32'(bus.ball_step), 32'd0);
      cyc();
      exp_sl = (exp_sl + 1) % 10;
      chk("pt_sl", 32'(bus.score_l), 32'(exp_sl));
      chk("pt_sr", 32'(bus.score_r), 32'd1);
`ifdef PONG_SCORE_LIMIT_EN
      if (exp_sl == 9) begin
        chk("over_flag", 32'(bus.game_over), 32'd1);
        chk("over_noload", 32'(bus.ball_load), 32'd0);
      end else begin
        chk("pt_load", 32'(bus.ball_load), 32'd1);
        chk("pt_over", 32'(bus.game_over), 32'd0);
        serve(P);
      end
`else
      chk("pt_load", 32'(bus.ball_load), 32'd1);
      chk("pt_over", 32'(bus.game_over), 32'd0);
      serve(P);
`endif
    end
`ifdef PONG_SCORE_LIMIT_EN
    tick(12'd300, 12'd200, 12'd0, 12'd0);
    chk("over_frozen_step", 32'(bus.ball_step), 32'd0);
    chk("over_held_sl", 32'(bus.score_l), 32'd9);
    cyc();
    start_pulse();
    chk("restart_sl", 32'(bus.score_l), 32'd0);
    chk("restart_sr", 32'(bus.score_r), 32'd0);
    chk("restart_over", 32'(bus.game_over), 32'd0);
    serve(P);
`endif
    tick(12'd300, 12'd455, 12'd0, 12'd0);
    chk("pre_rst_vy", 32'(bus.vel_y), 32'(N));
    rst_n = 1'b0;
    #1;
    chk("midrst_load", 32'(bus.ball_load), 32'd0);
    chk("midrst_step", 32'(bus.ball_step), 32'd0);
    chk("midrst_vx", 32'(bus.vel_x), 32'(P));
    chk("midrst_vy", 32'(bus.vel_y), 32'(P));
    chk("midrst_sl", 32'(bus.score_l), 32'd0);
    chk("midrst_sr", 32'(bus.score_r), 32'd0);
    chk("midrst_over", 32'(bus.game_over), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    tick(12'd300, 12'd200, 12'd0, 12'd0);
    chk("post_rst_idle_step", 32'(bus.ball_step), 32'd0);
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
